text_writer: RTL
================

TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 Parameter COLS, default 20, characters per text row.
REQ-002 Parameter ROWS, default 4, text rows held in character RAM.
REQ-003 Parameter ADDR_W, default 7, character RAM address width; COLS*ROWS SHALL be at most 2**ADDR_W.
REQ-004 Port clk  input  1  system clock; all logic on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_data  input  8  character byte from upstream source.
REQ-007 Port in_valid  input  1  in_data is valid.
REQ-008 Port in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port waddr  output  ADDR_W  character RAM write address.
REQ-010 Port wdata  output  8  character RAM write data.
REQ-011 Port write_en  output  1  character RAM write strobe, one cycle per write.
REQ-012 Port cursor_x  output  5  current column, 0..COLS-1.
REQ-013 Port cursor_y  output  2  current row, 0..ROWS-1.
REQ-014 Port busy  output  1  high while a clear sequence is in progress.

Function
REQ-015 The block SHALL implement three states: CLEAR_ALL, IDLE and CLEAR_LINE.
REQ-016 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both high; in_ready SHALL equal (state==IDLE), registered.
REQ-017 RAM address SHALL be cursor_y*COLS + cursor_x, computed at ADDR_W bits with no truncation for the default parameters.
REQ-018 Printable byte (0x20..0x7E) accepted in cycle N: write_en=1, waddr=current cursor, wdata=byte in cycle N+1; cursor_x increments in the same update.
REQ-019 Printable byte at cursor_x=COLS-1: write occurs, cursor_x becomes 0, and the row advance rule (REQ-022) applies.
REQ-020 0x0D (CR): cursor_x becomes 0, no write.
REQ-021 0x0A (LF): row advance rule applies, cursor_x unchanged, no write.
REQ-022 Row advance: if cursor_y<ROWS-1, cursor_y increments; if cursor_y=ROWS-1, cursor_y becomes 0 and the state becomes CLEAR_LINE for row 0.
REQ-023 0x08 (BS): if cursor_x>0, cursor_x decrements and 0x20 is written at the new position one cycle later; if cursor_x=0, no action.
REQ-024 0x0C (FF): cursor becomes (0,0) and the state becomes CLEAR_ALL.
REQ-025 Any other byte SHALL be accepted and discarded with no write and no cursor change.
REQ-026 CLEAR_ALL SHALL write 0x20 to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, then enter IDLE.
REQ-027 CLEAR_LINE SHALL write 0x20 to the COLS addresses of cursor_y in ascending order, one per cycle, then enter IDLE.
REQ-028 busy SHALL be high in CLEAR_ALL and CLEAR_LINE and low in IDLE; in_ready SHALL be low whenever busy is high.
REQ-029 A write that causes a wrap SHALL complete before the first CLEAR_LINE write; the two writes SHALL never share a cycle.
REQ-030 write_en SHALL never be high for more than one address per cycle, and waddr SHALL never exceed COLS*ROWS-1.

Reset
REQ-031 While rst is high: write_en=0, waddr=0, wdata=0x20, cursor=(0,0), in_ready=0, busy=1, and state=CLEAR_ALL.
REQ-032 After rst falls, the block SHALL run a full CLEAR_ALL of COLS*ROWS cycles before in_ready first rises.
REQ-033 rst asserted mid-clear or mid-write SHALL abort the operation, and the block SHALL restart CLEAR_ALL from address 0.

Structure
REQ-034 Control-character codes (0x08, 0x0A, 0x0C, 0x0D), the blank code 0x20, and the state encoding SHALL live in a shared package, text_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the address multiply SHALL be a constant-coefficient computation.

Verification
REQ-036 Reset release -> 80 consecutive write_en pulses, waddr 0..79, wdata 0x20; then in_ready=1 and busy=0.
REQ-037 Send "HI" after the clear -> writes of 0x48 at address 0 and 0x49 at address 1, each one cycle after acceptance; cursor ends at (2,0).
REQ-038 Cursor at (19,3), send 0x41 -> write of 0x41 at address 79; then 20 writes of 0x20 at addresses 0..19; cursor ends at (0,0); in_ready is low for those 20 cycles.
REQ-039 Cursor at (5,1), send BS -> write of 0x20 at address 24, cursor (4,1); cursor at (0,2), send BS -> no write.
REQ-040 Cursor at (7,2), send CR then LF -> no writes, cursor (0,3); send 0x0C -> 80-cycle clear, cursor (0,0).
REQ-041 in_valid held high with 0x7F during a clear -> no acceptance until IDLE; after acceptance the byte is dropped with no write.

Source files
------------

// File: rtl/text_pkg.sv
// Shared character codes and controller state encoding for the text writer.
package text_pkg;

  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_BLANK    = 8'h20;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_CLEAR_ALL  = 2'd0,
    ST_IDLE       = 2'd1,
    ST_CLEAR_LINE = 2'd2
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_writer.sv
// Byte-stream to character-RAM writer with cursor, CR/LF/BS/FF handling and row/screen clears.
// One-cycle write latency after acceptance; in_ready drops for the whole of any clear sequence.
module text_writer
  import text_pkg::*;
#(
  parameter int COLS   = 20,
  parameter int ROWS   = 4,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata,
  output logic              write_en,
  output logic [4:0]        cursor_x,
  output logic [1:0]        cursor_y,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ALL  = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(COLS - 1);
  localparam logic [4:0]        X_LAST    = 5'(COLS - 1);
  localparam logic [1:0]        Y_LAST    = 2'(ROWS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic [4:0]          cx_q, cx_d;
  logic [1:0]          cy_q, cy_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                rdy_q, rdy_d;

  logic                accept, printable, at_x_last, at_y_last, row_adv, wrap;
  logic [ADDR_W-1:0]   line_base, cur_addr;

  assign line_base = ADDR_W'(cy_q) * ADDR_W'(COLS);
  assign cur_addr  = line_base + ADDR_W'(cx_q);
  assign accept    = in_valid && rdy_q;
  assign printable = is_printable(in_data);
  assign at_x_last = (cx_q == X_LAST);
  assign at_y_last = (cy_q == Y_LAST);
  assign row_adv   = accept && ((in_data == CH_LF) || (printable && at_x_last));
  assign wrap      = row_adv && at_y_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR_ALL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR_ALL: begin
        if (clr_q == LAST_ALL) state_d = ST_IDLE;
      end
      ST_CLEAR_LINE: begin
        if (clr_q == LAST_LINE) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept && (in_data == CH_FF)) state_d = ST_CLEAR_ALL;
        else if (wrap)                    state_d = ST_CLEAR_LINE;
      end
      default: state_d = ST_CLEAR_ALL;
    endcase
  end

  // Cursor, clear counter and write-port next values
  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    clr_d   = clr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_CLEAR_ALL: begin
        we_d    = 1'b1;
        waddr_d = clr_q;
        wdata_d = CH_BLANK;
        clr_d   = (clr_q == LAST_ALL) ? '0 : clr_q + 1'b1;
      end
      ST_CLEAR_LINE: begin
        we_d    = 1'b1;
        waddr_d = line_base + clr_q;
        wdata_d = CH_BLANK;
        clr_d   = (clr_q == LAST_LINE) ? '0 : clr_q + 1'b1;
      end
      ST_IDLE: begin
        clr_d = '0;
        if (accept) begin
          if (row_adv) cy_d = at_y_last ? 2'd0 : cy_q + 2'd1;
          case (in_data)
            CH_CR: cx_d = '0;
            CH_LF: begin
            end
            CH_BS: begin
              if (cx_q != 5'd0) begin
                cx_d    = cx_q - 5'd1;
                we_d    = 1'b1;
                waddr_d = cur_addr - ADDR_W'(1);
                wdata_d = CH_BLANK;
              end
            end
            CH_FF: begin
              cx_d = '0;
              cy_d = '0;
            end
            default: begin
              if (printable) begin
                we_d    = 1'b1;
                waddr_d = cur_addr;
                wdata_d = in_data;
                cx_d    = at_x_last ? 5'd0 : cx_q + 5'd1;
              end
            end
          endcase
        end
      end
      default: begin
      end
    endcase
  end

  // Ready lags the state by one cycle so it only rises once the last clear write is off the port.
  assign rdy_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= CH_BLANK;
      rdy_q   <= 1'b0;
    end else begin
      clr_q   <= clr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
    end
  end

  // Output logic
  always_comb begin
    in_ready = rdy_q;
    busy     = !rdy_q;
    write_en = we_q;
    waddr    = waddr_q;
    wdata    = wdata_q;
    cursor_x = cx_q;
    cursor_y = cy_q;
  end

endmodule
